// File: rtl/si_tag_pkg.sv
// si_tag_pkg
// Shared tag definitions for the tag converter, the tag serializer and the
// single-tag consumers downstream of them.
//   TAGTIME_W / CHANNEL_W : field widths (time in 1/3 ps, signed channel)
//   tag_t                 : packed {tagtime, channel} record
//   ltb_advances()        : wrap-safe "candidate bound is ahead of current"
package si_tag_pkg;

  localparam int TAGTIME_W = 64;
  localparam int CHANNEL_W = 6;

  typedef struct packed {
    logic [TAGTIME_W-1:0]        tagtime;
    logic signed [CHANNEL_W-1:0] channel;
  } tag_t;

  // The bound is a free-running 64-bit time, so compare by signed difference
  // rather than magnitude to stay correct across wrap.
  function automatic logic ltb_advances(input logic [TAGTIME_W-1:0] cand,
                                        input logic [TAGTIME_W-1:0] cur);
    logic [TAGTIME_W-1:0] diff;
    diff = cand - cur;
    return $signed(diff) > 64'sd0;
  endfunction

endpackage

// File: rtl/si_tag_serializer_if.sv
// si_tag_serializer_if
// Bundles the multi-lane input beat stream, the single-tag output stream and
// the lowest-time-bound side signals of the tag serializer.
//   s_axis_*            : input beat (NUMBER_OF_WORDS lanes, per-lane keep)
//   s_lowest_time_bound : upstream lower bound on future tag times
//   m_axis_*            : one tag per transfer, tlast on last tag of a beat
//   m_lowest_time_bound : lower bound on any tag not yet emitted
// Modports: slave = serializer side, master = producer/consumer side.
interface si_tag_serializer_if #(
  parameter int NUMBER_OF_WORDS = 4
);
  import si_tag_pkg::*;

  logic                        s_axis_tvalid;
  logic                        s_axis_tready;
  logic [TAGTIME_W-1:0]        s_axis_tagtime [NUMBER_OF_WORDS];
  logic signed [CHANNEL_W-1:0] s_axis_channel [NUMBER_OF_WORDS];
  logic [NUMBER_OF_WORDS-1:0]  s_axis_tkeep;
  logic [TAGTIME_W-1:0]        s_lowest_time_bound;

  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [TAGTIME_W-1:0]        m_axis_tagtime;
  logic signed [CHANNEL_W-1:0] m_axis_channel;
  logic                        m_axis_tlast;
  logic [TAGTIME_W-1:0]        m_lowest_time_bound;

  modport slave (
    input  s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep,
    input  s_lowest_time_bound, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel,
    output m_axis_tlast, m_lowest_time_bound
  );

  modport master (
    output s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep,
    output s_lowest_time_bound, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel,
    input  m_axis_tlast, m_lowest_time_bound
  );

endinterface

// File: rtl/si_lowest_bit_select.sv
// si_lowest_bit_select
// Purely combinational priority encoder over a lane mask.
//   i_mask  : lane mask
//   o_idx   : index of the lowest set bit (0 when mask is empty)
//   o_valid : mask has at least one bit set
//   o_rest  : mask with that lowest set bit cleared
module si_lowest_bit_select #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rest
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = IDX_W'(i);
      end else begin
        o_idx = o_idx;
      end
    end
  end

  // x & (x - 1) clears exactly the lowest set bit.
  always_comb begin
    o_valid = |i_mask;
    o_rest  = i_mask & (i_mask - WIDTH'(1'b1));
  end

endmodule

// File: rtl/si_tag_serializer.sv
// si_tag_serializer
// Turns multi-lane tag beats (sparse keep) into one tag per cycle in
// ascending lane order, and forwards a monotonic lowest-time-bound that never
// overtakes a tag still waiting to be emitted.
//   clk, rst : clock, synchronous active-high reset
//   io_bus   : si_tag_serializer_if.slave (s_axis_* in, m_axis_* out,
//              s_/m_lowest_time_bound)
module si_tag_serializer
  import si_tag_pkg::*;
#(
  parameter int NUMBER_OF_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  si_tag_serializer_if.slave   io_bus
);

  localparam int IDX_W = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1;

  tag_t                       r_hold [NUMBER_OF_WORDS];
  logic [NUMBER_OF_WORDS-1:0] r_pend;
  logic [TAGTIME_W-1:0]       r_ltb;

  logic [IDX_W-1:0]           w_idx;
  logic                       w_any;
  logic [NUMBER_OF_WORDS-1:0] w_rest;
  logic                       w_last;
  logic                       w_fire;
  logic                       w_s_ready;
  logic                       w_accept;

  si_lowest_bit_select #(
    .WIDTH (NUMBER_OF_WORDS)
  ) u_sel (
    .i_mask  (r_pend),
    .o_idx   (w_idx),
    .o_valid (w_any),
    .o_rest  (w_rest)
  );

  assign w_last    = (w_rest == {NUMBER_OF_WORDS{1'b0}});
  assign w_fire    = w_any && io_bus.m_axis_tready;
  // Taking a new beat while the last pending tag leaves gives zero-bubble
  // beat-to-beat hand-over; the only comb path is m_axis_tready -> s_axis_tready.
  assign w_s_ready = !w_any || (w_fire && w_last);
  assign w_accept  = io_bus.s_axis_tvalid && w_s_ready;

  assign io_bus.s_axis_tready       = w_s_ready;
  assign io_bus.m_axis_tvalid       = w_any;
  assign io_bus.m_axis_tagtime      = r_hold[w_idx].tagtime;
  assign io_bus.m_axis_channel      = r_hold[w_idx].channel;
  assign io_bus.m_axis_tlast        = w_last;
  assign io_bus.m_lowest_time_bound = r_ltb;

  // Pending mask and hold registers; a new beat fully replaces the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= {NUMBER_OF_WORDS{1'b0}};
      for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
        r_hold[i].tagtime <= 64'd0;
        r_hold[i].channel <= 6'sd0;
      end
    end else if (w_accept) begin
      r_pend <= io_bus.s_axis_tkeep;
      for (int i = 0; i < NUMBER_OF_WORDS; i++) begin
        r_hold[i].tagtime <= io_bus.s_axis_tagtime[i];
        r_hold[i].channel <= io_bus.s_axis_channel[i];
      end
    end else if (w_fire) begin
      r_pend <= w_rest;
    end else begin
      r_pend <= r_pend;
    end
  end

  // Bound follows emitted tags; it only tracks upstream while fully idle so it
  // can never jump past a tag still held here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ltb <= 64'd0;
    end else if (w_fire) begin
      r_ltb <= r_hold[w_idx].tagtime;
    end else if (!w_any && !w_accept &&
                 ltb_advances(io_bus.s_lowest_time_bound, r_ltb)) begin
      r_ltb <= io_bus.s_lowest_time_bound;
    end else begin
      r_ltb <= r_ltb;
    end
  end

endmodule

// File: tb/tb_si_tag_serializer.sv
module tb_si_tag_serializer;
  import si_tag_pkg::*;

  localparam int NW = 4;

  typedef struct {
    logic [63:0]       t;
    logic signed [5:0] ch;
    logic              last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  exp_t        sb_q [$];
  exp_t        head;
  logic [63:0] exp_ltb;
  logic        was_empty;
  logic        exp_fire;
  logic        exp_tready;
  logic        acc;

  si_tag_serializer_if #(.NUMBER_OF_WORDS(NW)) bus ();

  si_tag_serializer #(.NUMBER_OF_WORDS(NW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: pushes expected tags when a beat is accepted, pops on output fire.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_ltb = 64'd0;
    end else begin
      was_empty  = (sb_q.size() == 0);
      exp_fire   = !was_empty && bus.m_axis_tready;
      exp_tready = was_empty || (exp_fire && sb_q[0].last);
      n_tests++;
      if (bus.m_axis_tvalid !== !was_empty) begin
        n_fail++;
        $display("FAIL sb_tvalid: got %b expected %b", bus.m_axis_tvalid, !was_empty);
      end
      n_tests++;
      if (bus.s_axis_tready !== exp_tready) begin
        n_fail++;
        $display("FAIL sb_s_tready: got %b expected %b", bus.s_axis_tready, exp_tready);
      end
      n_tests++;
      if (bus.m_lowest_time_bound !== exp_ltb) begin
        n_fail++;
        $display("FAIL sb_ltb: got %0d expected %0d", bus.m_lowest_time_bound, exp_ltb);
      end
      acc = bus.s_axis_tvalid && exp_tready;
      if (exp_fire) begin
        head = sb_q.pop_front();
        n_tests++;
        if (bus.m_axis_tagtime !== head.t || bus.m_axis_channel !== head.ch ||
            bus.m_axis_tlast !== head.last) begin
          n_fail++;
          $display("FAIL sb_tag: got t=%0d ch=%0d last=%b expected t=%0d ch=%0d last=%b",
                   bus.m_axis_tagtime, bus.m_axis_channel, bus.m_axis_tlast,
                   head.t, head.ch, head.last);
        end
        exp_ltb = head.t;
      end else if (was_empty && !acc &&
                   $signed(bus.s_lowest_time_bound - exp_ltb) > 64'sd0) begin
        exp_ltb = bus.s_lowest_time_bound;
      end
      if (acc) begin
        for (int i = 0; i < NW; i++) begin
          if (bus.s_axis_tkeep[i]) begin
            head.t    = bus.s_axis_tagtime[i];
            head.ch   = bus.s_axis_channel[i];
            head.last = ((bus.s_axis_tkeep >> (i + 1)) == 4'd0);
            sb_q.push_back(head);
          end
        end
      end
    end
  end

  task automatic set_beat(input logic v, input logic [3:0] keep,
                          input logic [63:0] t0, input logic [63:0] t1,
                          input logic [63:0] t2, input logic [63:0] t3,
                          input logic signed [5:0] c0, input logic signed [5:0] c1,
                          input logic signed [5:0] c2, input logic signed [5:0] c3);
    bus.s_axis_tvalid     = v;
    bus.s_axis_tkeep      = keep;
    bus.s_axis_tagtime[0] = t0;
    bus.s_axis_tagtime[1] = t1;
    bus.s_axis_tagtime[2] = t2;
    bus.s_axis_tagtime[3] = t3;
    bus.s_axis_channel[0] = c0;
    bus.s_axis_channel[1] = c1;
    bus.s_axis_channel[2] = c2;
    bus.s_axis_channel[3] = c3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_lowest_time_bound = 64'd0;
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: got tvalid=%b tready=%b expected 0 1",
               bus.m_axis_tvalid, bus.s_axis_tready);
    end
    n_tests++;
    if (bus.m_lowest_time_bound !== 64'd0 || bus.m_axis_tagtime !== 64'd0 ||
        bus.m_axis_channel !== 6'sd0) begin
      n_fail++;
      $display("FAIL reset_data: got ltb=%0d t=%0d ch=%0d expected 0 0 0",
               bus.m_lowest_time_bound, bus.m_axis_tagtime, bus.m_axis_channel);
    end
  endtask

  task automatic test_dense();
    logic [63:0]       et [4];
    logic signed [5:0] ec [4];
    et = '{64'd100, 64'd200, 64'd300, 64'd400};
    ec = '{6'sd1, 6'sd2, -6'sd3, 6'sd4};
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b1111, 64'd100, 64'd200, 64'd300, 64'd400, 6'sd1, 6'sd2, -6'sd3, 6'sd4);
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL dense_accept: got tready=%b expected 1", bus.s_axis_tready);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tagtime !== et[k] ||
          bus.m_axis_channel !== ec[k] || bus.m_axis_tlast !== (k == 3) ||
          bus.s_axis_tready !== (k == 3)) begin
        n_fail++;
        $display("FAIL dense_tag%0d: got v=%b t=%0d ch=%0d last=%b sr=%b expected 1 %0d %0d %b %b",
                 k, bus.m_axis_tvalid, bus.m_axis_tagtime, bus.m_axis_channel,
                 bus.m_axis_tlast, bus.s_axis_tready, et[k], ec[k], (k == 3), (k == 3));
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_lowest_time_bound !== 64'd400) begin
      n_fail++;
      $display("FAIL dense_end: got v=%b ltb=%0d expected 0 400",
               bus.m_axis_tvalid, bus.m_lowest_time_bound);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] et [4];
    et = '{64'd100, 64'd200, 64'd300, 64'd400};
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b1111, 64'd100, 64'd200, 64'd300, 64'd400, 6'sd1, 6'sd2, -6'sd3, 6'sd4);
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tagtime !== 64'd100) begin
      n_fail++;
      $display("FAIL bp_first: got t=%0d expected 100", bus.m_axis_tagtime);
    end
    @(posedge clk);
    #1;
    bus.m_axis_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tagtime !== 64'd200 ||
          bus.s_axis_tready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b t=%0d sr=%b expected 1 200 0",
                 c, bus.m_axis_tvalid, bus.m_axis_tagtime, bus.s_axis_tready);
      end
      @(posedge clk);
      #1;
    end
    bus.m_axis_tready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.m_axis_tagtime !== et[k] || bus.m_axis_tlast !== (k == 3)) begin
        n_fail++;
        $display("FAIL bp_resume%0d: got t=%0d last=%b expected %0d %b",
                 k, bus.m_axis_tagtime, bus.m_axis_tlast, et[k], (k == 3));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b1010, 64'd0, 64'd50, 64'd0, 64'd60, 6'sd0, 6'sd5, 6'sd0, -6'sd6);
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b0001, 64'd70, 64'd0, 64'd0, 64'd0, 6'sd7, 6'sd0, 6'sd0, 6'sd0);
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tagtime !== 64'd50 || bus.m_axis_tlast !== 1'b0 ||
        bus.s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_50: got t=%0d last=%b sr=%b expected 50 0 0",
               bus.m_axis_tagtime, bus.m_axis_tlast, bus.s_axis_tready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tagtime !== 64'd60 || bus.m_axis_tlast !== 1'b1 ||
        bus.s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_60: got t=%0d last=%b sr=%b expected 60 1 1",
               bus.m_axis_tagtime, bus.m_axis_tlast, bus.s_axis_tready);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tagtime !== 64'd70 ||
        bus.m_axis_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_70: got v=%b t=%0d last=%b expected 1 70 1",
               bus.m_axis_tvalid, bus.m_axis_tagtime, bus.m_axis_tlast);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b expected 0", bus.m_axis_tvalid);
    end
  endtask

  task automatic test_idle_bound();
    logic [63:0] steps [4];
    logic [63:0] want [4];
    steps = '{64'd1000, 64'd2000, 64'd1500, 64'd1500};
    want  = '{64'd0, 64'd1000, 64'd2000, 64'd2000};
    for (int s = 0; s < 4; s++) begin
      @(posedge clk);
      #1;
      bus.s_lowest_time_bound = steps[s];
      @(negedge clk);
      n_tests++;
      if (bus.m_lowest_time_bound !== want[s]) begin
        n_fail++;
        $display("FAIL idle_ltb%0d: got %0d expected %0d", s, bus.m_lowest_time_bound, want[s]);
      end
    end
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b0001, 64'd2100, 64'd0, 64'd0, 64'd0, -6'sd1, 6'sd0, 6'sd0, 6'sd0);
    bus.m_axis_tready = 1'b0;
    bus.s_lowest_time_bound = 64'd5000;
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_lowest_time_bound !== 64'd2000 || bus.m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_ltb: got ltb=%0d v=%b expected 2000 1",
               bus.m_lowest_time_bound, bus.m_axis_tvalid);
    end
    @(posedge clk);
    #1;
    bus.m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (bus.m_lowest_time_bound !== 64'd2100) begin
      n_fail++;
      $display("FAIL fire_ltb: got %0d expected 2100", bus.m_lowest_time_bound);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (bus.m_lowest_time_bound !== 64'd5000) begin
      n_fail++;
      $display("FAIL idle_after_ltb: got %0d expected 5000", bus.m_lowest_time_bound);
    end
  endtask

  task automatic test_empty_and_reset();
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b0000, 64'd900, 64'd901, 64'd902, 64'd903, 6'sd1, 6'sd1, 6'sd1, 6'sd1);
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_accept: got sr=%b expected 1", bus.s_axis_tready);
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_no_out: got v=%b expected 0", bus.m_axis_tvalid);
    end
    @(posedge clk);
    #1;
    set_beat(1'b1, 4'b1111, 64'd100, 64'd200, 64'd300, 64'd400, 6'sd1, 6'sd2, -6'sd3, 6'sd4);
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.m_axis_tagtime !== 64'd300 || bus.m_lowest_time_bound !== 64'd200) begin
      n_fail++;
      $display("FAIL pre_reset: got t=%0d ltb=%0d expected 300 200",
               bus.m_axis_tagtime, bus.m_lowest_time_bound);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_lowest_time_bound !== 64'd0 ||
        bus.s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b ltb=%0d sr=%b expected 0 0 1",
               bus.m_axis_tvalid, bus.m_lowest_time_bound, bus.s_axis_tready);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.m_axis_tready = 1'b1;
    bus.s_lowest_time_bound = 64'd0;
    set_beat(1'b0, 4'b0000, 64'd0, 64'd0, 64'd0, 64'd0, 6'sd0, 6'sd0, 6'sd0, 6'sd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_dense();
    do_reset();
    test_backpressure();
    do_reset();
    test_back_to_back();
    do_reset();
    test_idle_bound();
    do_reset();
    test_empty_and_reset();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
